// File: rtl/alu_seq_cntrl.sv
// ALU sequencing controller: decodes one instruction into an ALU control word,
// registers it on acceptance and replays it over one or more datapath slices
// (beats), least significant slice first.
module alu_seq_cntrl #(
  parameter int N     = 16,
  parameter int SLICE = 8,
  parameter int BW    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    opCode,
  input  logic [1:0]    funct,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    aluOp,
  output logic          invA,
  output logic          invB,
  output logic          Cin,
  output logic          cinSel,
  output logic          sign,
  output logic [BW-1:0] beat,
  output logic          lastBeat,
  output logic          illegal
);

  // N must be a whole number of slices
  localparam int BEATS = N / SLICE;

  typedef enum logic {IDLE, ISSUE} stateT;

  stateT         state;
  logic [BW-1:0] beatReg;
  logic [2:0]    aluOpReg;
  logic          invAReg;
  logic          invBReg;
  logic          cinReg;
  logic          signReg;
  logic          illegalReg;

  logic [2:0]    decAluOp;
  logic          decInvA;
  logic          decInvB;
  logic          decCin;
  logic          decSign;
  logic          decIllegal;

  logic          multiBeat;
  logic          arith;
  logic          lastBeatInt;
  logic          accept;

  // Only add/xor/and-class legal ops span all slices; shifts and illegals take one beat
  assign multiBeat   = !illegalReg && aluOpReg[2];
  assign arith       = !illegalReg && (aluOpReg == 3'b100);
  assign lastBeatInt = multiBeat ? (beatReg == BW'(BEATS - 1)) : 1'b1;

  assign out_valid = (state == ISSUE);
  assign in_ready  = !flush && (!out_valid || (out_ready && lastBeatInt));
  assign accept    = in_valid && in_ready;

  assign aluOp    = aluOpReg;
  assign invA     = invAReg;
  assign invB     = invBReg;
  assign illegal  = illegalReg;
  assign beat     = beatReg;
  assign lastBeat = lastBeatInt;
  assign Cin      = (beatReg == '0) ? cinReg : 1'b0;
  assign cinSel   = (beatReg != '0) && arith;
  assign sign     = lastBeatInt && signReg;

  // Instruction decode table; anything unlisted is flagged illegal and run as a one-beat add
  always_comb begin
    decAluOp   = 3'b100;
    decInvA    = 1'b0;
    decInvB    = 1'b0;
    decCin     = 1'b0;
    decSign    = 1'b0;
    decIllegal = 1'b0;
    case (opCode)
      5'b01000: decSign = 1'b1;
      5'b01001: begin
        decInvA = 1'b1;
        decCin  = 1'b1;
        decSign = 1'b1;
      end
      5'b01010: decAluOp = 3'b101;
      5'b01011: begin
        decAluOp = 3'b110;
        decInvB  = 1'b1;
      end
      5'b11011: begin
        case (funct)
          2'b00: decSign = 1'b1;
          2'b01: begin
            decInvA = 1'b1;
            decCin  = 1'b1;
            decSign = 1'b1;
          end
          2'b10: decAluOp = 3'b101;
          default: begin
            decAluOp = 3'b110;
            decInvB  = 1'b1;
          end
        endcase
      end
      5'b10000, 5'b10001, 5'b10011: decSign = 1'b1;
      5'b11100, 5'b11101, 5'b11110: begin
        decInvB = 1'b1;
        decCin  = 1'b1;
        decSign = 1'b1;
      end
      5'b11111: decAluOp = 3'b100;
      5'b10100, 5'b10101, 5'b10110, 5'b10111: decAluOp = {1'b0, opCode[1:0]};
      5'b11010: decAluOp = {1'b0, funct};
      default: decIllegal = 1'b1;
    endcase
  end

  // Issue FSM: reset beats flush, flush beats acceptance, acceptance beats beat advance
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beatReg    <= '0;
      aluOpReg   <= '0;
      invAReg    <= 1'b0;
      invBReg    <= 1'b0;
      cinReg     <= 1'b0;
      signReg    <= 1'b0;
      illegalReg <= 1'b0;
    end else if (flush) begin
      state   <= IDLE;
      beatReg <= '0;
    end else if (accept) begin
      state      <= ISSUE;
      beatReg    <= '0;
      aluOpReg   <= decAluOp;
      invAReg    <= decInvA;
      invBReg    <= decInvB;
      cinReg     <= decCin;
      signReg    <= decSign;
      illegalReg <= decIllegal;
    end else if (out_valid && out_ready) begin
      if (lastBeatInt) begin
        state   <= IDLE;
        beatReg <= '0;
      end else begin
        beatReg <= beatReg + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_cntrl.sv
// Testbench for alu_seq_cntrl: a 2-slice (16/8) and a 4-slice (32/8) instance share
// all inputs; each is compared against a queue-of-beats reference model.
module tb_alu_seq_cntrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       flush;
  logic       out_ready;
  logic [4:0] opCode;
  logic [1:0] funct;

  logic       inReady16, outValid16, invA16, invB16, cin16, cinSel16, sign16, lastBeat16, illegal16;
  logic [2:0] aluOp16;
  logic [0:0] beat16;
  logic       inReady32, outValid32, invA32, invB32, cin32, cinSel32, sign32, lastBeat32, illegal32;
  logic [2:0] aluOp32;
  logic [1:0] beat32;

  alu_seq_cntrl #(.N(16), .SLICE(8), .BW(1)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady16), .opCode(opCode),
    .funct(funct), .flush(flush), .out_valid(outValid16), .out_ready(out_ready),
    .aluOp(aluOp16), .invA(invA16), .invB(invB16), .Cin(cin16), .cinSel(cinSel16),
    .sign(sign16), .beat(beat16), .lastBeat(lastBeat16), .illegal(illegal16)
  );

  alu_seq_cntrl #(.N(32), .SLICE(8), .BW(2)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady32), .opCode(opCode),
    .funct(funct), .flush(flush), .out_valid(outValid32), .out_ready(out_ready),
    .aluOp(aluOp32), .invA(invA32), .invB(invB32), .Cin(cin32), .cinSel(cinSel32),
    .sign(sign32), .beat(beat32), .lastBeat(lastBeat32), .illegal(illegal32)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] op;
    logic       rFmt;
    logic [1:0] fn;
    logic [2:0] aluOp;
    logic       invA, invB, cin, sign;
  } vecT;

  typedef struct packed {
    logic [2:0] aluOp;
    logic       invA, invB, cin, sign, illegal;
  } decT;

  typedef struct packed {
    logic [2:0] aluOp;
    logic       invA, invB, cin, cinSel, sign;
    logic [1:0] beat;
    logic       lastBeat, illegal;
  } wordT;

  vecT        vecs[23];
  logic [4:0] illegalOps[4];
  wordT       mq[2][$];
  bit         acc[2];
  bit         modelOn = 0;
  int         checks = 0;
  int         errors = 0;

  function automatic vecT mkVec(input logic [4:0] op, input logic rFmt, input logic [1:0] fn,
                                input logic [2:0] alu, input logic iA, input logic iB,
                                input logic c, input logic s);
    return {op, rFmt, fn, alu, iA, iB, c, s};
  endfunction

  // Table lookup; anything not found is illegal
  function automatic decT refDecode(input logic [4:0] op, input logic [1:0] f);
    decT d;
    d = {3'b100, 4'b0000, 1'b1};
    for (int i = 0; i < 23; i++)
      if (vecs[i].op == op && (!vecs[i].rFmt || vecs[i].fn == f))
        d = {vecs[i].aluOp, vecs[i].invA, vecs[i].invB, vecs[i].cin, vecs[i].sign, 1'b0};
    return d;
  endfunction

  function automatic int beatsOf(input int w);
    return (w == 0) ? 2 : 4;
  endfunction

  // Expands an accepted instruction into the list of control words the ALU should see
  task automatic loadModel(input int w, input decT d);
    int   nb;
    wordT x;
    nb = (!d.illegal && (d.aluOp == 3'b100 || d.aluOp == 3'b101 || d.aluOp == 3'b110)) ? beatsOf(w) : 1;
    mq[w].delete();
    for (int i = 0; i < nb; i++) begin
      x.aluOp    = d.aluOp;
      x.invA     = d.invA;
      x.invB     = d.invB;
      x.illegal  = d.illegal;
      x.cin      = (i == 0) ? d.cin : 1'b0;
      x.cinSel   = (i > 0) && (d.aluOp == 3'b100);
      x.sign     = (i == nb - 1) ? d.sign : 1'b0;
      x.beat     = 2'(i);
      x.lastBeat = (i == nb - 1);
      mq[w].push_back(x);
    end
  endtask

  function automatic wordT observed(input int w);
    if (w == 0)
      return {aluOp16, invA16, invB16, cin16, cinSel16, sign16, 1'b0, beat16, lastBeat16, illegal16};
    return {aluOp32, invA32, invB32, cin32, cinSel32, sign32, beat32, lastBeat32, illegal32};
  endfunction

  function automatic logic obsValid(input int w);
    return (w == 0) ? outValid16 : outValid32;
  endfunction

  function automatic logic obsReady(input int w);
    return (w == 0) ? inReady16 : inReady32;
  endfunction

  function automatic logic expReady(input int w);
    return !flush && (mq[w].size() == 0 || (out_ready && mq[w][0].lastBeat));
  endfunction

  task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput(input int w);
    logic ev;
    wordT e;
    wordT o;
    if (!modelOn) return;
    ev = (mq[w].size() != 0);
    checks++;
    if (obsValid(w) !== ev) begin
      errors++;
      $display("[TB] FAIL outValid[%0d] at %0t: got %b expected %b", w, $time, obsValid(w), ev);
    end
    checks++;
    if (obsReady(w) !== expReady(w)) begin
      errors++;
      $display("[TB] FAIL inReady[%0d] at %0t: got %b expected %b", w, $time, obsReady(w), expReady(w));
    end
    if (ev) begin
      e = mq[w][0];
      o = observed(w);
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL word[%0d] at %0t: got %h expected %h", w, $time, o, e);
      end
    end
  endtask

  task automatic modelUpdate(input int w);
    if (rst)
      mq[w].delete();
    else if (flush)
      mq[w].delete();
    else if (acc[w])
      loadModel(w, refDecode(opCode, funct));
    else if (mq[w].size() != 0 && out_ready)
      void'(mq[w].pop_front());
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [4:0] op,
                               input logic [1:0] f, input logic fl, input logic rdy);
    rst       = r;
    in_valid  = v;
    opCode    = op;
    funct     = f;
    flush     = fl;
    out_ready = rdy;
    #1;
  endtask

  // One clock: compare on the falling edge, then advance the model across the rising edge
  task automatic tick();
    @(negedge clk);
    checkOutput(0);
    checkOutput(1);
    for (int w = 0; w < 2; w++) acc[w] = in_valid && expReady(w);
    @(posedge clk);
    for (int w = 0; w < 2; w++) modelUpdate(w);
    modelOn = 1;
    #1;
  endtask

  task automatic drain();
    applyStimulus(0, 0, 5'd0, 2'd0, 0, 1);
    repeat (5) tick();
  endtask

  // Reset, table sweep, corner sequences, then random traffic
  initial begin
    vecs[0]  = mkVec(5'b01000, 0, 2'b00, 3'b100, 0, 0, 0, 1);
    vecs[1]  = mkVec(5'b01001, 0, 2'b00, 3'b100, 1, 0, 1, 1);
    vecs[2]  = mkVec(5'b01010, 0, 2'b00, 3'b101, 0, 0, 0, 0);
    vecs[3]  = mkVec(5'b01011, 0, 2'b00, 3'b110, 0, 1, 0, 0);
    vecs[4]  = mkVec(5'b11011, 1, 2'b00, 3'b100, 0, 0, 0, 1);
    vecs[5]  = mkVec(5'b11011, 1, 2'b01, 3'b100, 1, 0, 1, 1);
    vecs[6]  = mkVec(5'b11011, 1, 2'b10, 3'b101, 0, 0, 0, 0);
    vecs[7]  = mkVec(5'b11011, 1, 2'b11, 3'b110, 0, 1, 0, 0);
    vecs[8]  = mkVec(5'b10000, 0, 2'b00, 3'b100, 0, 0, 0, 1);
    vecs[9]  = mkVec(5'b10001, 0, 2'b00, 3'b100, 0, 0, 0, 1);
    vecs[10] = mkVec(5'b10011, 0, 2'b00, 3'b100, 0, 0, 0, 1);
    vecs[11] = mkVec(5'b11100, 0, 2'b00, 3'b100, 0, 1, 1, 1);
    vecs[12] = mkVec(5'b11101, 0, 2'b00, 3'b100, 0, 1, 1, 1);
    vecs[13] = mkVec(5'b11110, 0, 2'b00, 3'b100, 0, 1, 1, 1);
    vecs[14] = mkVec(5'b11111, 0, 2'b00, 3'b100, 0, 0, 0, 0);
    vecs[15] = mkVec(5'b10100, 0, 2'b00, 3'b000, 0, 0, 0, 0);
    vecs[16] = mkVec(5'b10101, 0, 2'b00, 3'b001, 0, 0, 0, 0);
    vecs[17] = mkVec(5'b10110, 0, 2'b00, 3'b010, 0, 0, 0, 0);
    vecs[18] = mkVec(5'b10111, 0, 2'b00, 3'b011, 0, 0, 0, 0);
    vecs[19] = mkVec(5'b11010, 1, 2'b00, 3'b000, 0, 0, 0, 0);
    vecs[20] = mkVec(5'b11010, 1, 2'b01, 3'b001, 0, 0, 0, 0);
    vecs[21] = mkVec(5'b11010, 1, 2'b10, 3'b010, 0, 0, 0, 0);
    vecs[22] = mkVec(5'b11010, 1, 2'b11, 3'b011, 0, 0, 0, 0);
    illegalOps[0] = 5'b00100;
    illegalOps[1] = 5'b00000;
    illegalOps[2] = 5'b11001;
    illegalOps[3] = 5'b10010;

    applyStimulus(1, 0, 5'd0, 2'd0, 0, 0);
    tick();
    tick();
    checkVal("rstValid16", outValid16, 0);
    checkVal("rstBeat16", beat16, 0);
    checkVal("rstAluOp16", aluOp16, 0);
    checkVal("rstInv16", {invA16, invB16}, 0);
    checkVal("rstCin16", {cin16, cinSel16}, 0);
    checkVal("rstSign16", sign16, 0);
    checkVal("rstIllegal16", illegal16, 0);
    checkVal("rstValid32", outValid32, 0);
    checkVal("rstBeat32", beat32, 0);

    for (int i = 0; i < 23; i++) begin
      applyStimulus(0, 1, vecs[i].op, vecs[i].rFmt ? vecs[i].fn : 2'($urandom_range(0, 3)), 0, 1);
      tick();
      applyStimulus(0, 0, 5'd0, 2'd0, 0, 1);
      repeat (4) tick();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, illegalOps[i], 2'($urandom_range(0, 3)), 0, 1);
      tick();
      applyStimulus(0, 0, 5'd0, 2'd0, 0, 1);
      repeat (2) tick();
    end

    // SUB over two slices
    drain();
    applyStimulus(0, 1, 5'b11011, 2'b01, 0, 1);
    tick();
    applyStimulus(0, 0, 5'd0, 2'd0, 0, 1);
    checkVal("subB0Valid", outValid16, 1);
    checkVal("subB0Beat", beat16, 0);
    checkVal("subB0AluOp", aluOp16, 3'b100);
    checkVal("subB0InvA", invA16, 1);
    checkVal("subB0Cin", {cin16, cinSel16}, 2'b10);
    checkVal("subB0Sign", {sign16, lastBeat16}, 2'b00);
    tick();
    checkVal("subB1Beat", beat16, 1);
    checkVal("subB1Cin", {cin16, cinSel16}, 2'b01);
    checkVal("subB1Sign", {sign16, lastBeat16}, 2'b11);
    tick();
    checkVal("subDone", outValid16, 0);

    // RORI then back-to-back ADD
    drain();
    applyStimulus(0, 1, 5'b10110, 2'b00, 0, 1);
    tick();
    applyStimulus(0, 1, 5'b11011, 2'b00, 0, 1);
    checkVal("roriAluOp", aluOp16, 3'b010);
    checkVal("roriLast", lastBeat16, 1);
    checkVal("roriReady16", inReady16, 1);
    checkVal("roriReady32", inReady32, 1);
    tick();
    applyStimulus(0, 0, 5'd0, 2'd0, 0, 1);
    checkVal("b2bValid16", outValid16, 1);
    checkVal("b2bBeat16", beat16, 0);
    checkVal("b2bAluOp16", aluOp16, 3'b100);
    checkVal("b2bValid32", outValid32, 1);

    // SLT stalled on beat 0
    drain();
    applyStimulus(0, 1, 5'b11101, 2'b00, 0, 0);
    tick();
    applyStimulus(0, 1, 5'b11111, 2'b00, 0, 0);
    for (int c = 0; c < 3; c++) begin
      checkVal("sltStallBeat", {outValid16, beat16}, 2'b10);
      checkVal("sltStallWord", {aluOp16, invB16, cin16, sign16}, 6'b100110);
      checkVal("sltStallReady", inReady16, 0);
      tick();
    end
    applyStimulus(0, 0, 5'd0, 2'd0, 0, 1);
    checkVal("sltB0", beat16, 0);
    tick();
    checkVal("sltB1", {beat16, sign16, lastBeat16}, 3'b111);
    tick();
    checkVal("sltDone", outValid16, 0);

    // Flush on beat 0 of ADD with a request waiting
    drain();
    applyStimulus(0, 1, 5'b11011, 2'b00, 0, 0);
    tick();
    applyStimulus(0, 1, 5'b01010, 2'b00, 1, 1);
    checkVal("flushReady", inReady16, 0);
    tick();
    applyStimulus(0, 1, 5'b01010, 2'b00, 0, 1);
    checkVal("flushValid", {outValid16, beat16}, 2'b00);
    checkVal("flushReadyAfter", inReady16, 1);
    tick();
    applyStimulus(0, 0, 5'd0, 2'd0, 0, 1);
    checkVal("flushNext", {outValid16, aluOp16, beat16}, 5'b1_101_0);

    // Illegal opcode is single-beat on both widths
    drain();
    applyStimulus(0, 1, 5'b00100, 2'b00, 0, 1);
    tick();
    applyStimulus(0, 0, 5'd0, 2'd0, 0, 1);
    checkVal("illegal16", {illegal16, lastBeat16}, 2'b11);
    checkVal("illegal32", {illegal32, lastBeat32}, 2'b11);
    tick();
    checkVal("illegalDone", {outValid16, outValid32}, 2'b00);

    // ADDI over four slices
    drain();
    applyStimulus(0, 1, 5'b01000, 2'b00, 0, 1);
    tick();
    applyStimulus(0, 0, 5'd0, 2'd0, 0, 1);
    for (int b = 0; b < 4; b++) begin
      checkVal("addi32Beat", beat32, 8'(b));
      checkVal("addi32CinSel", cinSel32, (b > 0) ? 8'd1 : 8'd0);
      checkVal("addi32Sign", {sign32, lastBeat32}, (b == 3) ? 8'd3 : 8'd0);
      tick();
    end
    checkVal("addi32Done", outValid32, 0);

    // Reset on beat 1 of a four-slice XOR, then SEQ
    drain();
    applyStimulus(0, 1, 5'b11011, 2'b10, 0, 1);
    tick();
    applyStimulus(0, 0, 5'd0, 2'd0, 0, 1);
    tick();
    checkVal("xor32Beat1", {outValid32, beat32}, 3'b101);
    applyStimulus(1, 0, 5'd0, 2'd0, 0, 1);
    tick();
    applyStimulus(0, 0, 5'd0, 2'd0, 0, 1);
    checkVal("rstMidValid", {outValid32, beat32}, 0);
    checkVal("rstMidWord", {aluOp32, invA32, invB32, cin32, cinSel32, sign32, illegal32}, 0);
    applyStimulus(0, 1, 5'b11100, 2'b00, 0, 1);
    tick();
    applyStimulus(0, 0, 5'd0, 2'd0, 0, 1);
    checkVal("seqAfterRst", {outValid32, beat32, invB32, cin32}, 5'b1_00_11);
    drain();

    for (int c = 0; c < 1500; c++) begin
      logic [4:0] op;
      if ($urandom_range(0, 99) < 75) op = vecs[$urandom_range(0, 22)].op;
      else op = 5'($urandom_range(0, 31));
      applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 70, op,
                    2'($urandom_range(0, 3)), $urandom_range(0, 99) < 5,
                    $urandom_range(0, 99) < 70);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_cntrl.md
ALU_SEQ_CNTRL -- requirements
Module: alu_seq_cntrl

Interface
REQ-001 Parameter N, default 16, operand width in bits.
REQ-002 Parameter SLICE, default 8, ALU datapath slice width; N SHALL be an integer multiple of SLICE; BEATS = N/SLICE.
REQ-003 Parameter BW, default 1, beat-index width, max(1, clog2(BEATS)).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  decode request present.
REQ-007 in_ready  out  1  request accepted on the edge where in_valid && in_ready.
REQ-008 opCode  in  5  instruction opcode.
REQ-009 funct  in  2  R-format function field.
REQ-010 flush  in  1  discard the in-flight instruction.
REQ-011 out_valid  out  1  control word valid for the current beat.
REQ-012 out_ready  in  1  ALU consumes the current beat.
REQ-013 aluOp  out  3  000 ROL, 001 SLL, 010 ROR, 011 SRL, 100 ADD, 101 XOR, 110 AND.
REQ-014 invA, invB  out  1 each  invert A / B before the slice.
REQ-015 Cin  out  1  slice carry-in, used when cinSel=0.
REQ-016 cinSel  out  1  1 = slice carry-in from the carry stored on the previous beat.
REQ-017 sign  out  1  signed overflow/compare evaluation on this beat.
REQ-018 beat  out  BW  current slice index, 0 = least significant.
REQ-019 lastBeat  out  1  current beat is the final beat.
REQ-020 illegal  out  1  opcode/funct not in the decode table.

Function
REQ-021 Decode (aluOp,invA,invB,Cin,sign): ADDI 01000 / ADD 11011-00 -> 100,0,0,0,1; SUBI 01001 / SUB 11011-01 -> 100,1,0,1,1; XORI 01010 / XOR 11011-10 -> 101,0,0,0,0; ANDNI 01011 / ANDN 11011-11 -> 110,0,1,0,0.
REQ-022 Decode: ST 10000, LD 10001, STU 10011 -> 100,0,0,0,1; SEQ 11100, SLT 11101, SLE 11110 -> 100,0,1,1,1; SCO 11111 -> 100,0,0,0,0.
REQ-023 Decode: ROLI 10100 / 11010-00 -> 000; SLLI 10101 / 11010-01 -> 001; RORI 10110 / 11010-10 -> 010; SRLI 10111 / 11010-11 -> 011; inv*, Cin, sign all 0.
REQ-024 Any other opcode -> aluOp 100, invA/invB/Cin/sign 0, illegal=1.
REQ-025 Arithmetic ops (aluOp 100) and logic ops (101, 110) issue BEATS beats; shift/rotate ops and illegal ops issue exactly 1 beat.
REQ-026 The decoded word is registered on acceptance; outputs depend only on that register and the beat counter, never combinationally on opCode/funct.
REQ-027 Latency: a request accepted at edge k SHALL present out_valid=1, beat=0 in the cycle following edge k.
REQ-028 Beat 0: cinSel=0, Cin=decoded value; beats>0 of an aluOp=100 op: cinSel=1, Cin=0; logic ops: cinSel=0, Cin=0 on every beat.
REQ-029 sign SHALL equal the decoded value only on the lastBeat cycle and 0 otherwise; invA, invB, aluOp, and illegal are held constant across all beats.
REQ-030 The beat counter increments on each edge with out_valid && out_ready && !lastBeat; lastBeat = (beat == BEATS-1) for multi-beat ops, 1 for single-beat ops.
REQ-031 With out_valid=1 and out_ready=0, all outputs SHALL hold.
REQ-032 in_ready = !flush && (!out_valid || (out_ready && lastBeat)); back-to-back issue with no bubble SHALL be supported.
REQ-033 The final beat is consumed with no new acceptance -> out_valid=0, beat=0 next cycle.
REQ-034 flush=1 -> next cycle out_valid=0, beat=0, with no acceptance that edge, whatever in_valid/out_ready are.
REQ-035 States: IDLE (out_valid=0) and ISSUE (out_valid=1); IDLE->ISSUE on accept; ISSUE->IDLE on final-beat consume without accept, or on flush; ISSUE->ISSUE on accept at the final beat.

Reset
REQ-036 rst=1 at an edge -> out_valid=0, beat=0, and aluOp, invA, invB, Cin, cinSel, sign, illegal all 0 next cycle; rst has priority over flush and acceptance.
REQ-037 rst asserted mid-sequence SHALL abandon the instruction; the first request after rst deasserts starts at beat 0.

Verification (N=16, SLICE=8 unless stated)
REQ-038 SUB 11011/01, out_ready=1 -> beat0: 100,invA=1,Cin=1,cinSel=0,sign=0; beat1: cinSel=1,Cin=0,sign=1,lastBeat=1.
REQ-039 RORI 10110 -> single beat, aluOp=010, lastBeat=1; a second request held on in_valid is accepted on the same edge (no bubble).
REQ-040 SLT with out_ready=0 for 3 cycles on beat 0 -> outputs frozen, beat stays 0, in_ready=0; then 2 consume cycles complete it.
REQ-041 flush on beat 0 of ADD with in_valid=1 -> next cycle out_valid=0, request not accepted; the following cycle it is accepted.
REQ-042 Opcode 00100 -> illegal=1, single beat; N=32, SLICE=8 ADDI -> beats 0..3, cinSel=1 on beats 1-3, sign only on beat 3.
REQ-043 rst on beat 1 of a 4-beat XOR -> all outputs 0 next cycle; a new SEQ afterwards starts at beat 0 with invB=1, Cin=1.
